sun_pll_divn_prog: RTL and testbench
====================================

SUN_PLL_DIVN_PROG -- requirements
Module: sun_pll_divn_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8: divider counter width.
REQ-002 SHALL have parameter DIV_DEFAULT, default 128: ratio in effect after reset.
REQ-003 SHALL have parameter LOCK_TOL, default 2: allowed |period − ratio| in CK cycles.
REQ-004 SHALL have parameter LOCK_CNT, default 16: consecutive good windows needed for lock.
REQ-005 SHALL have port CK, input, 1 bit: the block's single clock (VCO output); all flops on its rising edge.
REQ-006 SHALL have port PWRUP_1V8, input, 1 bit: asynchronous active-low reset; low = reset.
REQ-007 SHALL have port DIV_N, input, WIDTH bits: requested feedback divide ratio.
REQ-008 SHALL have port CK_REF, input, 1 bit: reference clock, asynchronous to CK.
REQ-009 SHALL have port CK_FB, output, 1 bit: divided clock to the PFD.
REQ-010 SHALL have port LOCK, output, 1 bit: frequency-lock indication.
REQ-011 SHALL have port PERIOD, output, WIDTH+1 bits: last measured CK_REF period in CK cycles.

Function
REQ-012 Divider SHALL be a synchronous counter CNT over 0..N_ACT−1; no ripple clocking.
REQ-013 N_ACT SHALL load max(DIV_N,2) only in the cycle where CNT = N_ACT−1; a mid-period DIV_N change SHALL NOT alter the current period.
REQ-014 CK_FB SHALL be registered, equal to (CNT < floor(N_ACT/2)) one cycle late; odd N gives high floor(N/2), low ceil(N/2) cycles.
REQ-015 CK_REF SHALL pass a 2-flop synchroniser; a rising edge is detected on sync stage 2 high and stage 3 low.
REQ-016 Period counter PCNT SHALL increment each CK cycle, saturate at 2^(WIDTH+1)−1, and restart at 1 in the cycle after a detected edge.
REQ-017 On a detected edge, PERIOD SHALL load PCNT; the first edge after reset SHALL only arm measurement: no window evaluated, PERIOD unchanged.
REQ-018 An evaluated window SHALL be good when |PERIOD_new − N_ACT| ≤ LOCK_TOL, using N_ACT before any same-cycle update.
REQ-019 Good window SHALL increment GOOD_CNT, saturating at LOCK_CNT; bad window SHALL clear GOOD_CNT and LOCK.
REQ-020 LOCK SHALL be set in the cycle GOOD_CNT reaches LOCK_CNT and stay high until a clearing event.
REQ-021 PCNT saturation, meaning CK_REF lost, SHALL clear LOCK, clear GOOD_CNT and disarm measurement.
REQ-022 A change of N_ACT value SHALL clear LOCK and GOOD_CNT; this takes priority over a coincident good window.

Reset
REQ-023 PWRUP_1V8 low SHALL asynchronously set: CNT=0, N_ACT=DIV_DEFAULT, CK_FB=0, PCNT=0, PERIOD=0, GOOD_CNT=0, LOCK=0, synchroniser=0, armed=0.
REQ-024 Release SHALL be synchronous to CK by the integrator; first CK_FB high occurs one cycle after the first post-release edge.
REQ-025 Reset mid-operation SHALL abandon any partial period or window with no output glitch beyond the asynchronous clear.

Structure
REQ-026 A shared package SHALL hold the lock-state constants and the minimum-ratio constant (2).
REQ-027 The synchroniser SHALL be sub-module sun_pll_sync2: 1-bit, 2 stages, async active-low reset; all else in one module.

Verification
REQ-028 DIV_N=128, CK_REF period 128 CK -> CK_FB 64 high/64 low; LOCK rises after 1 arming edge + 16 good windows; PERIOD=128.
REQ-029 DIV_N=5 -> CK_FB 2 high/3 low; DIV_N=0 or 1 -> ratio 2, 1 high/1 low.
REQ-030 Locked at 128, DIV_N→100 at CNT=30 -> current period completes at 128, next period 100, LOCK falls at load.
REQ-031 Locked, CK_REF period steps 128→131 -> first window bad, LOCK low; 130 -> LOCK held.
REQ-032 Locked, CK_REF stopped -> LOCK falls when PCNT saturates at 511; restart needs 1 arming + 16 good edges.
REQ-033 PWRUP_1V8 low mid-period -> all outputs 0 immediately; after release ratio 128 regardless of DIV_N until first terminal count.

Source files
------------

// File: rtl/sun_pll_divn_prog_pkg.sv
// Shared constants for the PLL feedback divider / lock detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sun_pll_divn_prog_pkg;

  // Lock detector states: IDLE = measurement disarmed, ACQ = armed and
  // counting good windows, LOCKED = LOCK asserted.
  typedef enum logic [1:0] {
    LS_IDLE   = 2'b00,
    LS_ACQ    = 2'b01,
    LS_LOCKED = 2'b10
  } lock_state_t;

  // Smallest feedback ratio the divider will run at; lower requests are clamped.
  localparam int MIN_RATIO = 2;

endpackage

// File: rtl/sun_pll_sync2.sv
// 1-bit two-flop synchroniser into the i_clk domain.
// Latency: 2 i_clk cycles from i_d to o_q.
// Backpressure: none, free-running.
// Ports: i_clk clock, i_rst_n async active-low reset, i_d async input,
//        o_q synchronised output (stage 2).
module sun_pll_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/sun_pll_divn_prog.sv
// Programmable PLL feedback divider with reference-period frequency-lock detector.
// Latency: CK_FB registered 1 CK after the count; ref edge seen 2 CK after CK_REF rises.
// Backpressure: none; DIV_N is sampled only at the divider terminal count.
// Ports: CK (VCO clock), PWRUP_1V8 (async active-low reset), DIV_N (requested ratio),
//        CK_REF (async reference), CK_FB (divided clock), LOCK (frequency lock),
//        PERIOD (last measured CK_REF period in CK cycles).
module sun_pll_divn_prog
  import sun_pll_divn_prog_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIV_DEFAULT = 128,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             CK,
  input  logic             PWRUP_1V8,
  input  logic [WIDTH-1:0] DIV_N,
  input  logic             CK_REF,
  output logic             CK_FB,
  output logic             LOCK,
  output logic [WIDTH:0]   PERIOD
);

  localparam int             PW       = WIDTH + 1;
  localparam int             GW       = $clog2(LOCK_CNT + 1);
  localparam logic [PW-1:0]  PCNT_MAX = '1;

  // ---------------- divider ----------------
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_nact;
  logic             r_ck_fb;
  logic [WIDTH-1:0] w_nact_new;
  logic             w_tc;
  logic             w_nact_chg;

  assign w_tc       = (r_cnt == r_nact - WIDTH'(1));
  assign w_nact_new = (DIV_N < WIDTH'(MIN_RATIO)) ? WIDTH'(MIN_RATIO) : DIV_N;
  assign w_nact_chg = w_tc && (w_nact_new != r_nact);

  // Ratio only reloads at terminal count so a period in flight always completes.
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      r_cnt   <= '0;
      r_nact  <= WIDTH'(DIV_DEFAULT);
      r_ck_fb <= 1'b0;
    end else begin
      r_ck_fb <= (r_cnt < (r_nact >> 1));
      if (w_tc) begin
        r_cnt  <= '0;
        r_nact <= w_nact_new;
      end else begin
        r_cnt  <= r_cnt + WIDTH'(1);
      end
    end
  end

  // ---------------- reference edge detect ----------------
  logic w_ref_s2;
  logic r_ref_s3;
  logic w_edge;

  sun_pll_sync2 u_sync (
    .i_clk   (CK),
    .i_rst_n (PWRUP_1V8),
    .i_d     (CK_REF),
    .o_q     (w_ref_s2)
  );

  assign w_edge = w_ref_s2 & ~r_ref_s3;

  // ---------------- period measurement ----------------
  logic [PW-1:0] r_pcnt;
  logic [PW-1:0] r_period;
  logic [PW-1:0] w_nact_ext;
  logic [PW-1:0] w_diff;
  logic          w_sat;
  logic          w_armed;
  logic          w_eval;
  logic          w_good;

  lock_state_t   r_state;
  lock_state_t   w_state_nxt;
  logic [GW-1:0] r_good_cnt;
  logic [GW-1:0] w_good_nxt;
  logic          r_lock;

  // A saturated counter means the reference has gone away.
  assign w_sat      = (r_pcnt == PCNT_MAX);
  assign w_armed    = (r_state != LS_IDLE);
  assign w_eval     = w_edge && w_armed && !w_sat;
  assign w_nact_ext = {1'b0, r_nact};
  assign w_diff     = (r_pcnt >= w_nact_ext) ? (r_pcnt - w_nact_ext) : (w_nact_ext - r_pcnt);
  assign w_good     = (w_diff <= PW'(LOCK_TOL));

  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      r_ref_s3 <= 1'b0;
      r_pcnt   <= '0;
      r_period <= '0;
    end else begin
      r_ref_s3 <= w_ref_s2;
      if (w_edge)      r_pcnt <= PW'(1);
      else if (!w_sat) r_pcnt <= r_pcnt + PW'(1);
      if (w_eval)      r_period <= r_pcnt;
    end
  end

  // ---------------- lock FSM ----------------
  always_ff @(posedge CK or negedge PWRUP_1V8) begin
    if (!PWRUP_1V8) begin
      r_state    <= LS_IDLE;
      r_good_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_lock     <= (w_state_nxt == LS_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    if (w_sat) begin
      // Reference lost: drop everything; a coincident edge re-arms only.
      w_good_nxt  = '0;
      w_state_nxt = w_edge ? LS_ACQ : LS_IDLE;
    end else if (w_edge) begin
      if (!w_armed) begin
        w_state_nxt = LS_ACQ;
      end else if (!w_good) begin
        w_good_nxt  = '0;
        w_state_nxt = LS_ACQ;
      end else begin
        if (r_good_cnt != GW'(LOCK_CNT)) w_good_nxt = r_good_cnt + GW'(1);
        if (w_good_nxt == GW'(LOCK_CNT)) w_state_nxt = LS_LOCKED;
      end
    end
    // A new ratio invalidates any history, even a good window this cycle.
    if (w_nact_chg) begin
      w_good_nxt = '0;
      if (w_state_nxt == LS_LOCKED) w_state_nxt = LS_ACQ;
    end
  end

  assign CK_FB  = r_ck_fb;
  assign LOCK   = r_lock;
  assign PERIOD = r_period;

endmodule

// File: tb/tb_sun_pll_divn_prog.sv
module tb_sun_pll_divn_prog;

  localparam int W    = 8;
  localparam int TOL  = 2;
  localparam int LCNT = 16;
  localparam int PMAX = 511;

  logic         CK = 1'b0;
  logic         PWRUP_1V8 = 1'b0;
  logic [W-1:0] DIV_N = 8'd128;
  logic         CK_REF = 1'b0;
  logic         CK_FB;
  logic         LOCK;
  logic [W:0]   PERIOD;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model of the lock detector, evaluated once per reference rise.
  bit m_armed, m_lock, m_have_last;
  int m_good, m_period, m_nact, last_rise;

  sun_pll_divn_prog dut (
    .CK        (CK),
    .PWRUP_1V8 (PWRUP_1V8),
    .DIV_N     (DIV_N),
    .CK_REF    (CK_REF),
    .CK_FB     (CK_FB),
    .LOCK      (LOCK),
    .PERIOD    (PERIOD)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_lock = 0; m_good = 0; m_period = 0; m_have_last = 0;
  endtask

  task automatic model_sat();
    m_armed = 0; m_good = 0; m_lock = 0;
  endtask

  task automatic check_lock(input string tag);
    chk({tag, "_lock"}, LOCK, m_lock);
    chk({tag, "_period"}, PERIOD, m_period);
  endtask

  // One reference period of length p CK cycles, rising at its start.
  task automatic ref_pulse(input int p, input string tag);
    int gap, d;
    @(negedge CK);
    gap = cyc - last_rise;
    if (m_have_last && gap > PMAX) model_sat();
    check_lock(tag);
    CK_REF = 1'b1;
    if (!m_armed) begin
      m_armed = 1;
    end else begin
      m_period = gap;
      d = gap - m_nact;
      if (d < 0) d = -d;
      if (d <= TOL) begin
        if (m_good < LCNT) m_good++;
        if (m_good == LCNT) m_lock = 1;
      end else begin
        m_good = 0;
        m_lock = 0;
      end
    end
    m_have_last = 1;
    last_rise = cyc;
    repeat (p / 2) @(negedge CK);
    CK_REF = 1'b0;
    repeat (p - p / 2 - 1) @(negedge CK);
  endtask

  task automatic ref_pulses(input int p, input int n, input string tag);
    for (int i = 0; i < n; i++) ref_pulse(p, tag);
  endtask

  // Reference stops: lock must survive until the period counter saturates.
  task automatic ref_stop();
    @(negedge CK);
    while (cyc - last_rise < 508) @(negedge CK);
    chk("stop_pre_sat_lock", LOCK, m_lock);
    while (cyc - last_rise < 516) @(negedge CK);
    model_sat();
    check_lock("stop_sat");
  endtask

  task automatic wait_level(input logic lvl);
    int k = 0;
    while (CK_FB !== lvl && k < 600) begin k++; @(negedge CK); end
    if (k >= 600) chk("tmo_wait_fb", 0, 1);
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (CK_FB === lvl && n < 600) begin n++; @(negedge CK); end
    if (n >= 600) chk("tmo_count_fb", 0, 1);
  endtask

  task automatic measure_fb(output int hi, output int lo);
    @(negedge CK);
    wait_level(1'b0);
    wait_level(1'b1);
    count_level(1'b1, hi);
    count_level(1'b0, lo);
  endtask

  initial begin
    int hi, lo, v, n, c0, p, len;
    int vals[$];

    model_reset();
    m_nact = 128;
    last_rise = 0;

    // Reset state
    repeat (3) @(negedge CK);
    chk("rst_ckfb", CK_FB, 0);
    chk("rst_lock", LOCK, 0);
    chk("rst_period", PERIOD, 0);
    PWRUP_1V8 = 1'b1;

    // Divider ratios: fixed corners plus random values
    vals = '{128, 5, 0, 1, 2, 3, 255};
    for (int i = 0; i < 5; i++) vals.push_back($urandom_range(0, 40));
    vals.push_back(128);
    foreach (vals[i]) begin
      v = vals[i];
      @(negedge CK);
      DIV_N = W'(v);
      measure_fb(hi, lo);
      measure_fb(hi, lo);
      n = (v < 2) ? 2 : v;
      chk($sformatf("div%0d_hi", v), hi, n / 2);
      chk($sformatf("div%0d_lo", v), lo, n - n / 2);
    end

    // Acquisition: 1 arming edge + 16 good windows
    ref_pulses(128, 17, "acq");
    check_lock("acq_end");
    chk("acq_locked", LOCK, 1);
    chk("acq_period", PERIOD, 128);

    // 131 window is out of tolerance
    ref_pulses(131, 1, "step131");
    ref_pulses(128, 1, "step131");
    check_lock("step131_end");
    chk("step131_unlock", LOCK, 0);

    // Relock then 130 windows stay within tolerance
    ref_pulses(128, 17, "relock");
    ref_pulses(130, 3, "hold130");
    ref_pulses(128, 1, "hold130");
    check_lock("hold130_end");
    chk("hold130_lock", LOCK, 1);
    chk("hold130_period", PERIOD, 130);

    // Reference lost, then restart from scratch
    ref_stop();
    ref_pulses(128, 16, "restart");
    check_lock("restart_16");
    chk("restart_16_lock", LOCK, 0);
    ref_pulses(128, 1, "restart");
    check_lock("restart_end");
    chk("restart_lock", LOCK, 1);

    // Random period runs around the ratio
    for (int r = 0; r < 12; r++) begin
      p = 128 + $urandom_range(0, 8) - 4;
      len = $urandom_range(1, 20);
      ref_pulses(p, len, "rnd");
    end

    // Mid-period ratio change while locked
    ref_pulses(128, 17, "prechg");
    check_lock("prechg_end");
    chk("prechg_lock", LOCK, 1);
    @(negedge CK);
    wait_level(1'b0);
    wait_level(1'b1);
    c0 = cyc;
    repeat (29) @(negedge CK);
    DIV_N = 8'd100;
    chk("chg_lock_held", LOCK, 1);
    wait_level(1'b0);
    wait_level(1'b1);
    chk("chg_cur_period", cyc - c0, 128);
    chk("chg_lock_drop", LOCK, 0);
    count_level(1'b1, hi);
    count_level(1'b0, lo);
    chk("chg_new_hi", hi, 50);
    chk("chg_new_lo", lo, 50);
    m_nact = 100; m_good = 0; m_lock = 0;

    // Reset mid-period with CK_FB high and PERIOD non-zero
    DIV_N = 8'd20;
    repeat (10) @(negedge CK);
    chk("pre_rst_ckfb", CK_FB, 1);
    PWRUP_1V8 = 1'b0;
    #1;
    chk("midrst_ckfb", CK_FB, 0);
    chk("midrst_lock", LOCK, 0);
    chk("midrst_period", PERIOD, 0);
    repeat (3) @(negedge CK);
    PWRUP_1V8 = 1'b1;
    model_reset();
    m_nact = 128;
    @(negedge CK);
    chk("rel_first_fb", CK_FB, 1);
    count_level(1'b1, hi);
    count_level(1'b0, lo);
    chk("rel_hi128", hi, 64);
    chk("rel_lo128", lo, 64);
    count_level(1'b1, hi);
    count_level(1'b0, lo);
    chk("rel_hi20", hi, 10);
    chk("rel_lo20", lo, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
